// File: rtl/model_arithmetic_pkg.sv
// Shared types and constants for the scalar arithmetic blocks of the NTM datapath.
package model_arithmetic_pkg;

  // Zero value used when clearing datapath registers.
  localparam int ZERO_DATA = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ITERATE = 2'd1,
    FINISH  = 2'd2
  } divider_state_t;

  // Largest positive two's-complement value of a data_size-bit word, zero-extended to 64 bits.
  function automatic logic [63:0] sat_max_pos(input int data_size);
    return (64'd1 << (data_size - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of a data_size-bit word, as its low data_size bits.
  function automatic logic [63:0] sat_max_neg(input int data_size);
    return 64'd1 << (data_size - 1);
  endfunction

endpackage

// File: rtl/model_scalar_fixed_iterative_divider.sv
// Signed fixed-point scalar divider: radix-2 restoring division on magnitudes,
// one quotient bit per cycle, truncation toward zero, saturation on overflow
// and divide-by-zero.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for START; latches sign, magnitudes, clears datapath
//   ITERATE | one restoring shift/subtract step per cycle, N steps in total
//   FINISH  | saturate/sign-restore, register outputs, pulse READY
module model_scalar_fixed_iterative_divider
  import model_arithmetic_pkg::*;
#(
  parameter int DATA_SIZE     = 64,
  parameter int CONTROL_SIZE  = 64,
  parameter int FRACTION_SIZE = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] DATA_A_IN,
  input  logic [DATA_SIZE-1:0] DATA_B_IN,
  output logic [DATA_SIZE-1:0] DATA_OUT,
  output logic                 OVERFLOW_OUT
);

  localparam int N = DATA_SIZE + FRACTION_SIZE;

  localparam logic [DATA_SIZE-1:0] MAX_POS = DATA_SIZE'(sat_max_pos(DATA_SIZE));
  localparam logic [DATA_SIZE-1:0] MAX_NEG = DATA_SIZE'(sat_max_neg(DATA_SIZE));

  // Quotient limits seen as unsigned N-bit magnitudes.
  localparam logic [N-1:0] Q_POS_LIMIT = N'(MAX_POS);
  localparam logic [N-1:0] Q_NEG_LIMIT = N'(MAX_NEG);

  divider_state_t          state;
  logic                    sign_q;
  logic                    dbz_q;
  logic [DATA_SIZE-1:0]    abs_b_q;
  logic [N-1:0]            dividend_q;
  logic [DATA_SIZE-1:0]    rem_q;
  logic [N-1:0]            quotient_q;
  logic [CONTROL_SIZE-1:0] counter_q;

  logic [DATA_SIZE:0]      rem_shift;
  logic [DATA_SIZE-1:0]    rem_sub;
  logic                    q_bit;

  // Magnitude as unsigned; the most negative value maps to 2^(DATA_SIZE-1).
  function automatic logic [DATA_SIZE-1:0] magnitude(input logic [DATA_SIZE-1:0] v);
    return v[DATA_SIZE-1] ? (~v + 1'b1) : v;
  endfunction

  // Re-apply the result sign to a magnitude; negating zero stays zero.
  function automatic logic [DATA_SIZE-1:0] apply_sign(input logic [DATA_SIZE-1:0] mag,
                                                      input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  // One restoring step: bring in the next dividend bit and trial-subtract |B|.
  // When the subtraction succeeds the result is below |B|, so DATA_SIZE bits suffice.
  always_comb begin
    rem_shift = {rem_q, dividend_q[N-1]};
    q_bit     = (rem_shift >= {1'b0, abs_b_q});
    rem_sub   = rem_shift[DATA_SIZE-1:0] - abs_b_q;
  end

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      sign_q       <= 1'b0;
      dbz_q        <= 1'b0;
      abs_b_q      <= '0;
      dividend_q   <= '0;
      rem_q        <= '0;
      quotient_q   <= '0;
      counter_q    <= '0;
      READY        <= 1'b0;
      DATA_OUT     <= DATA_SIZE'(ZERO_DATA);
      OVERFLOW_OUT <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          READY <= 1'b0;
          if (START) begin
            sign_q     <= DATA_A_IN[DATA_SIZE-1] ^ DATA_B_IN[DATA_SIZE-1];
            abs_b_q    <= magnitude(DATA_B_IN);
            dividend_q <= N'(magnitude(DATA_A_IN)) << FRACTION_SIZE;
            rem_q      <= '0;
            quotient_q <= '0;
            counter_q  <= CONTROL_SIZE'(N);
            dbz_q      <= (DATA_B_IN == '0);
            state      <= (DATA_B_IN == '0) ? FINISH : ITERATE;
          end
        end

        ITERATE: begin
          READY      <= 1'b0;
          rem_q      <= q_bit ? rem_sub : rem_shift[DATA_SIZE-1:0];
          dividend_q <= dividend_q << 1;
          quotient_q <= (quotient_q << 1) | N'(q_bit);
          counter_q  <= counter_q - 1'b1;
          if (counter_q == CONTROL_SIZE'(1)) begin
            state <= FINISH;
          end
        end

        FINISH: begin
          READY <= 1'b1;
          state <= IDLE;
          if (dbz_q) begin
            // B was zero, so the sign is the sign of A; a zero dividend stays zero.
            OVERFLOW_OUT <= 1'b1;
            if (dividend_q == '0) begin
              DATA_OUT <= DATA_SIZE'(ZERO_DATA);
            end else begin
              DATA_OUT <= sign_q ? MAX_NEG : MAX_POS;
            end
          end else if (!sign_q) begin
            if (quotient_q > Q_POS_LIMIT) begin
              DATA_OUT     <= MAX_POS;
              OVERFLOW_OUT <= 1'b1;
            end else begin
              DATA_OUT     <= quotient_q[DATA_SIZE-1:0];
              OVERFLOW_OUT <= 1'b0;
            end
          end else begin
            if (quotient_q > Q_NEG_LIMIT) begin
              DATA_OUT     <= MAX_NEG;
              OVERFLOW_OUT <= 1'b1;
            end else begin
              DATA_OUT     <= apply_sign(quotient_q[DATA_SIZE-1:0], 1'b1);
              OVERFLOW_OUT <= 1'b0;
            end
          end
        end

        default: begin
          READY <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
